// File: rtl/divider_fixed_point_16_bit_if.sv
// Operand/result bundle shared by the fixed-point divider and whoever drives it.
// The master side issues start with a/b; the slave side answers with
// q_result/overflow and the busy/done handshake.
interface divider_fixed_point_16_bit_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] q_result;
  logic         overflow;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b,
    input  q_result, overflow, busy, done
  );

  modport slave (
    input  start, a, b,
    output q_result, overflow, busy, done
  );
endinterface

// File: rtl/divider_fixed_point_16_bit.sv
// Iterative signed fixed-point divider, q_result = a / b in Q(N-Q).Q.
// Magnitudes are divided by restoring long division, one quotient bit per
// clock, then the sign is reapplied and the result saturated to N bits.
// Division by zero runs the normal datapath and forces a saturated result.
module divider_fixed_point_16_bit #(
  parameter int N = 16,
  parameter int Q = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  divider_fixed_point_16_bit_if.slave   bus
);

  localparam int W  = N + Q;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] POS_MAX = W'((2 ** (N - 1)) - 1);
  localparam logic [W-1:0] NEG_MAX = W'(2 ** (N - 1));

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t        state;
  state_t        next_state;

  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd;
  logic [W-1:0]  quot;
  logic [N:0]    rem;
  logic [N-1:0]  bmag;
  logic          sign;
  logic          a_neg;
  logic          b_zero;

  logic [N-1:0]  q_reg;
  logic          ov_reg;
  logic          done_reg;

  logic [N-1:0]  amag_in;
  logic [N-1:0]  bmag_in;
  logic [N+1:0]  rem_sh;
  logic [N+1:0]  diff;
  logic          take;
  logic [N:0]    rem_next;
  logic [N-1:0]  res_val;
  logic          res_ov;

  // Unsigned magnitudes of the incoming operands; 0x8000 maps to 32768.
  always_comb begin
    amag_in = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
    bmag_in = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem, dvd[W-1]};
    diff     = rem_sh - {2'b00, bmag};
    take     = ~diff[N+1];
    rem_next = take ? diff[N:0] : rem_sh[N:0];
  end

  // Sign application and saturation of the finished magnitude quotient.
  always_comb begin
    res_val = '0;
    res_ov  = 1'b0;
    if (b_zero) begin
      res_ov  = 1'b1;
      res_val = a_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else if (!sign) begin
      if (quot > POS_MAX) begin
        res_ov  = 1'b1;
        res_val = {1'b0, {(N-1){1'b1}}};
      end else begin
        res_val = quot[N-1:0];
      end
    end else begin
      if (quot > NEG_MAX) begin
        res_ov  = 1'b1;
        res_val = {1'b1, {(N-1){1'b0}}};
      end else begin
        res_val = ~quot[N-1:0] + 1'b1;
      end
    end
  end

  // Next-state logic: accept in IDLE, iterate in CALC until the counter expires, one FIN edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = CALC;
      CALC:    if (cnt == '0) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath: operand capture, division steps, and result registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      dvd      <= '0;
      quot     <= '0;
      rem      <= '0;
      bmag     <= '0;
      sign     <= 1'b0;
      a_neg    <= 1'b0;
      b_zero   <= 1'b0;
      q_reg    <= '0;
      ov_reg   <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= (state == FIN);
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd    <= {amag_in, {Q{1'b0}}};
            bmag   <= bmag_in;
            sign   <= bus.a[N-1] ^ bus.b[N-1];
            a_neg  <= bus.a[N-1];
            b_zero <= (bus.b == '0);
            rem    <= '0;
            quot   <= '0;
            cnt    <= CW'(W - 1);
          end
        end
        CALC: begin
          dvd  <= {dvd[W-2:0], 1'b0};
          rem  <= rem_next;
          quot <= {quot[W-2:0], take};
          cnt  <= cnt - 1'b1;
        end
        FIN: begin
          q_reg  <= res_val;
          ov_reg <= res_ov;
        end
        default: ;
      endcase
    end
  end

  // busy stays up through the done cycle so it falls together with done.
  always_comb begin
    bus.q_result = q_reg;
    bus.overflow = ov_reg;
    bus.done     = done_reg;
    bus.busy     = (state != IDLE) || done_reg;
  end

endmodule

// File: tb/tb_divider_fixed_point_16_bit.sv
// Self-checking bench for the fixed-point divider: directed cases from the
// operator's definition, handshake/reset corner cases, and random operands
// compared against an arithmetic reference model.
module tb_divider_fixed_point_16_bit;

  localparam int LAT = 29;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  divider_fixed_point_16_bit_if #(.N(16)) bus ();

  divider_fixed_point_16_bit #(.N(16), .Q(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: divide the real-valued operands with plain integer arithmetic.
  function automatic void refDiv(input logic [15:0] av, input logic [15:0] bv,
                                 output logic [15:0] q, output logic ov);
    longint sa, sb, m;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (sb == 0) begin
      ov = 1'b1;
      q  = (sa < 0) ? 16'h8000 : 16'h7FFF;
      return;
    end
    m  = ((sa < 0 ? -sa : sa) * 4096) / (sb < 0 ? -sb : sb);
    ov = 1'b0;
    if ((sa < 0) != (sb < 0)) begin
      if (m > 32768) begin
        ov = 1'b1;
        q  = 16'h8000;
      end else begin
        q = 16'(-m);
      end
    end else begin
      if (m > 32767) begin
        ov = 1'b1;
        q  = 16'h7FFF;
      end else begin
        q = 16'(m);
      end
    end
  endfunction

  // Present operands with a one-cycle start; returns 1ns after the accepting edge.
  task automatic startOp(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done, bounded; notes whether busy ever dropped on the way.
  task automatic waitDone(output int edges, output logic busyGap);
    edges   = 0;
    busyGap = 1'b0;
    while (bus.done !== 1'b1 && edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy !== 1'b1) busyGap = 1'b1;
    end
  endtask

  // Full operation with latency, busy, result and post-done checks.
  task automatic applyStimulus(input string tag, input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] expQ, input logic expOv);
    int   edges;
    logic gap;
    startOp(av, bv);
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    waitDone(edges, gap);
    checkOutput({tag, "_latency"}, edges, LAT);
    checkOutput({tag, "_busy"}, {31'd0, gap}, 32'd0);
    checkOutput({tag, "_q"}, {16'd0, bus.q_result}, {16'd0, expQ});
    checkOutput({tag, "_ov"}, {31'd0, bus.overflow}, {31'd0, expOv});
    @(posedge clk);
    #1;
    checkOutput({tag, "_donepulse"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, "_busyfall"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, "_hold"}, {16'd0, bus.q_result}, {16'd0, expQ});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        ov;
  } vec_t;

  vec_t dirVecs[10] = '{
    '{16'h3000, 16'h1800, 16'h2000, 1'b0},
    '{16'h1000, 16'h3000, 16'h0555, 1'b0},
    '{16'hF000, 16'h0800, 16'hE000, 1'b0},
    '{16'hF000, 16'h3000, 16'hFAAB, 1'b0},
    '{16'h8000, 16'h1000, 16'h8000, 1'b0},
    '{16'h7000, 16'h0400, 16'h7FFF, 1'b1},
    '{16'h1000, 16'h0000, 16'h7FFF, 1'b1},
    '{16'hF000, 16'h0000, 16'h8000, 1'b1},
    '{16'h0000, 16'h1234, 16'h0000, 1'b0},
    '{16'h0000, 16'h0000, 16'h7FFF, 1'b1}
  };

  initial begin : main
    int          edges;
    logic        gap;
    logic        sawDone;
    logic [15:0] ra, rb, rq;
    logic        rov;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset with start held high.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 16'h3000;
    bus.b     = 16'h1800;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_q", {16'd0, bus.q_result}, 32'd0);
    checkOutput("rst_ov", {31'd0, bus.overflow}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_idle", {31'd0, bus.busy}, 32'd0);

    // Directed operand table.
    foreach (dirVecs[i])
      applyStimulus($sformatf("dir%0d", i), dirVecs[i].a, dirVecs[i].b, dirVecs[i].q, dirVecs[i].ov);

    // start pulsed mid-CALC with other operands must be ignored.
    startOp(16'h3000, 16'h1800);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus.a     = 16'h1000;
    bus.b     = 16'h3000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(edges, gap);
    checkOutput("ign_latency", edges + 6, LAT);
    checkOutput("ign_q", {16'd0, bus.q_result}, 32'h2000);
    @(posedge clk);
    #1;
    checkOutput("ign_noqueue", {31'd0, bus.busy}, 32'd0);

    // start held high across done: second op accepted on the edge after done.
    startOp(16'hF000, 16'h0800);
    bus.a     = 16'h1000;
    bus.b     = 16'h3000;
    bus.start = 1'b1;
    waitDone(edges, gap);
    checkOutput("b2b_lat1", edges, LAT);
    checkOutput("b2b_q1", {16'd0, bus.q_result}, 32'hE000);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("b2b_busy", {31'd0, bus.busy}, 32'd1);
    checkOutput("b2b_done", {31'd0, bus.done}, 32'd0);
    waitDone(edges, gap);
    checkOutput("b2b_lat2", edges, LAT);
    checkOutput("b2b_q2", {16'd0, bus.q_result}, 32'h0555);
    @(posedge clk);
    #1;

    // Reset during CALC discards the operation.
    startOp(16'h7000, 16'h0400);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mrst_q", {16'd0, bus.q_result}, 32'd0);
    checkOutput("mrst_ov", {31'd0, bus.overflow}, 32'd0);
    checkOutput("mrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("mrst_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    sawDone = 1'b0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("mrst_quiet", {31'd0, sawDone}, 32'd0);
    applyStimulus("mrst_fresh", 16'hF000, 16'h3000, 16'hFAAB, 1'b0);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom_range(0, 15));
        1:       rb = 16'($urandom_range(0, 4095)) | (($urandom_range(0, 1) == 1) ? 16'hF000 : 16'h0000);
        default: rb = 16'($urandom);
      endcase
      refDiv(ra, rb, rq, rov);
      applyStimulus($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, rq, rov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider_fixed_point_16_bit.md
Name: divider_fixed_point_16_bit

Overview:
- Iterative signed fixed-point divider producing q_result = a / b in Q(N-Q).Q format (Q4.12 at defaults).
- It is the inverse operator to the team's fixed-point multiplier and shares the same clk/start/a/b/q_result/overflow interface style.
- It adds busy/done handshaking because the operation is multi-cycle.
- It sits in the VAE datapath wherever normalisation or reciprocal scaling is needed.

Parameters:
- N, 16, total word width in bits (two's complement).
- Q, 12, number of fractional bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  N  dividend, signed Q(N-Q).Q.
- b  input  N  divisor, signed Q(N-Q).Q.
- q_result  output  N  quotient, signed Q(N-Q).Q, truncated toward zero, saturated.
- overflow  output  1  result saturated or divide-by-zero; valid with done.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when q_result/overflow update.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; q_result=0, overflow=0, busy=0, done=0; internal registers cleared. Reset takes priority over everything, including mid-operation: the in-flight result is discarded and no done pulse is issued.
- States:
  - IDLE: on an edge with start=1, capture a and b. Compute sign = a[N-1] XOR b[N-1]. Capture magnitudes |a| and |b| as N-bit unsigned; |0x8000| = 32768 is representable unsigned. Set busy=1, set the iteration counter to N+Q-1, go to CALC.
  - CALC: restoring long division of the (N+Q)-bit value {|a|, Q zeros} by |b|, one quotient bit per edge, MSB first. Partial remainder is N+1 bits wide. Counter decrements each edge; after the edge where counter=0, go to FIN. CALC lasts exactly N+Q edges (28 at defaults).
  - FIN (1 edge): apply sign and saturation, register q_result and overflow, pulse done=1, clear busy, return to IDLE.
- Latency: accepting edge E. Edges E+1 through E+N+Q perform CALC. done=1 and the new q_result are visible after edge E+N+Q+1 (29 edges at defaults) and remain for one cycle. busy is high from after E through the cycle in which done is high, i.e. busy falls together with done.
- Back-to-back: start may be high in the same cycle as done; it is accepted on the next edge.
- start while busy is ignored, with no queuing. a and b may change freely after the accepting edge.
- q_result and overflow hold their values until the next FIN or reset.
- Let M be the (N+Q)-bit unsigned magnitude quotient.
  - Positive result: if M > 2^(N-1)-1, q_result=0x7FFF and overflow=1; otherwise q_result=M.
  - Negative result: if M > 2^(N-1), q_result=0x8000 and overflow=1; otherwise q_result = -M (M = 2^(N-1) gives 0x8000 with no overflow).
  - Rounding is truncation toward zero; remainder is discarded.
- Divide by zero (b=0): latency is still N+Q+1 (datapath runs normally). The result is forced to overflow=1, with q_result=0x7FFF if a[N-1]=0 (including a=0) and 0x8000 if a[N-1]=1.
- Zero dividend with nonzero b: q_result=0, overflow=0. A negative zero never arises.

Test Plan:
- Reset with start held high: rst=1 for 2 cycles -> q_result=0, overflow=0, busy=0, done=0; no operation starts until rst=0.
- Basic and latency:
  - a=0x3000 (3.0), b=0x1800 (1.5), start for one cycle -> done exactly 29 edges after the accepting edge, q_result=0x2000, overflow=0; busy high throughout.
  - a=0x1000, b=0x3000 -> 0x0555.
- Signs:
  - a=0xF000 (-1.0), b=0x0800 (0.5) -> 0xE000.
  - a=0xF000, b=0x3000 -> 0xFAAB.
  - a=0x8000, b=0x1000 -> 0x8000, overflow=0.
- Saturation and divide by zero:
  - a=0x7000, b=0x0400 -> 0x7FFF, overflow=1.
  - a=0x1000, b=0 -> 0x7FFF, overflow=1.
  - a=0xF000, b=0 -> 0x8000, overflow=1.
- Handshake:
  - Pulse start again mid-CALC with different operands -> ignored; first result delivered unchanged.
  - start held high across done -> second operation accepted on the edge after done.
- Reset mid-operation: assert rst at cycle 10 of CALC -> all outputs 0 next cycle, no done pulse; a fresh start afterwards gives the correct result with full latency.
